// File: rtl/cnn_pkg.sv
// Shared widths, FSM state encoding and output saturation for the CNN datapath.
package cnn_pkg;

    localparam int DATA_W    = 9;
    localparam int ROW_W     = 5 * DATA_W;
    localparam int FRAC_BITS = 4;
    localparam int ACC_W     = 24;

    typedef enum logic [5:0] {
        idle = 6'b000001,
        m_1  = 6'b000010,
        m_2  = 6'b000100,
        m_3  = 6'b001000,
        m_4  = 6'b010000,
        m_5  = 6'b100000
    } state_t;

    function automatic logic [DATA_W-1:0] sat9(input logic signed [ACC_W-1:0] v);
        if (v > ACC_W'(255))
            return 9'h0FF;
        else if (v < ACC_W'(-256))
            return 9'h100;
        else
            return v[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/conv_row_mac.sv
// Combinational signed dot product of two packed 5-element rows.
module conv_row_mac
    import cnn_pkg::*;
(
    input  logic        [ROW_W-1:0] row_x,
    input  logic        [ROW_W-1:0] row_w,
    output logic signed [ACC_W-1:0] dot
);

    logic signed [2*DATA_W-1:0] prod [5];

    always_comb begin
        dot = '0;
        for (int unsigned j = 0; j < 5; j++) begin
            prod[j] = $signed(row_x[j*DATA_W +: DATA_W]) * $signed(row_w[j*DATA_W +: DATA_W]);
            dot     = dot + ACC_W'(prod[j]);
        end
    end

endmodule

// File: rtl/conv_5x5.sv
// 5x5 window MAC: one kernel row per cycle through a shared row MAC, then bias,
// scale and saturate to 9 bits.
module conv_5x5
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              x_valid,
    input  logic [ROW_W-1:0]  x_m_1,
    input  logic [ROW_W-1:0]  x_m_2,
    input  logic [ROW_W-1:0]  x_m_3,
    input  logic [ROW_W-1:0]  x_m_4,
    input  logic [ROW_W-1:0]  x_m_5,
    input  logic [ROW_W-1:0]  weight_m_1,
    input  logic [ROW_W-1:0]  weight_m_2,
    input  logic [ROW_W-1:0]  weight_m_3,
    input  logic [ROW_W-1:0]  weight_m_4,
    input  logic [ROW_W-1:0]  weight_m_5,
    input  logic [DATA_W-1:0] bias,
    output logic              conv_valid,
    output logic [DATA_W-1:0] conv_data
);

    state_t                  state, state_nxt;
    logic        [ROW_W-1:0] row_x, row_w;
    logic signed [ACC_W-1:0] dot, acc, bias_ext, total;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= idle;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            idle:    if (x_valid) state_nxt = m_1;
            m_1:     state_nxt = m_2;
            m_2:     state_nxt = m_3;
            m_3:     state_nxt = m_4;
            m_4:     state_nxt = m_5;
            m_5:     state_nxt = x_valid ? m_1 : idle;
            default: state_nxt = idle;
        endcase
    end

    always_comb begin
        row_x = '0;
        row_w = '0;
        unique case (state)
            m_1:     begin row_x = x_m_1; row_w = weight_m_1; end
            m_2:     begin row_x = x_m_2; row_w = weight_m_2; end
            m_3:     begin row_x = x_m_3; row_w = weight_m_3; end
            m_4:     begin row_x = x_m_4; row_w = weight_m_4; end
            m_5:     begin row_x = x_m_5; row_w = weight_m_5; end
            default: ;
        endcase
    end

    conv_row_mac u_row_mac (
        .row_x (row_x),
        .row_w (row_w),
        .dot   (dot)
    );

    // Bias is in output Q-format; align it to the product Q-format before adding.
    assign bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    assign total    = acc + dot + (bias_ext <<< FRAC_BITS);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc        <= '0;
            conv_valid <= 1'b0;
            conv_data  <= '0;
        end else begin
            conv_valid <= 1'b0;
            unique case (state)
                m_1:           acc <= dot;
                m_2, m_3, m_4: acc <= acc + dot;
                m_5: begin
                    conv_data  <= sat9(total >>> FRAC_BITS);
                    conv_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_5x5.sv
// Directed bench for conv_5x5 with a window-level reference model checked every cycle.
module tb_conv_5x5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        x_valid;
    logic [44:0] xr [5];
    logic [44:0] wr [5];
    logic [8:0]  bias;
    logic        conv_valid;
    logic [8:0]  conv_data;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    int     phase;
    longint macc;
    int     exp_valid;
    int     exp_data;

    always #5 clk = ~clk;

    conv_5x5 dut (
        .clk        (clk),
        .rstn       (rstn),
        .x_valid    (x_valid),
        .x_m_1      (xr[0]),
        .x_m_2      (xr[1]),
        .x_m_3      (xr[2]),
        .x_m_4      (xr[3]),
        .x_m_5      (xr[4]),
        .weight_m_1 (wr[0]),
        .weight_m_2 (wr[1]),
        .weight_m_3 (wr[2]),
        .weight_m_4 (wr[3]),
        .weight_m_5 (wr[4]),
        .bias       (bias),
        .conv_valid (conv_valid),
        .conv_data  (conv_data)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint row_dot(input logic [44:0] a, input logic [44:0] b);
        longint s = 0;
        logic signed [8:0] ea, eb;
        for (int j = 0; j < 5; j++) begin
            ea = a[9*j +: 9];
            eb = b[9*j +: 9];
            s += longint'(ea) * longint'(eb);
        end
        return s;
    endfunction

    function automatic int finish_window(input longint sum, input logic [8:0] b);
        logic signed [8:0] sb = b;
        longint t = sum + longint'(sb) * 16;
        longint q = t >>> 4;
        if (q > 255)  return 255;
        if (q < -256) return -256;
        return int'(q);
    endfunction

    // Window-level model: a window starts on an accepted x_valid, consumes row k
    // in the k-th following cycle, and reports in the cycle after the fifth row.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase = 0; macc = 0; exp_valid = 0; exp_data = 0;
        end else begin
            exp_valid = 0;
            if (phase == 0) begin
                if (x_valid) phase = 1;
            end else begin
                if (phase == 1) macc = row_dot(xr[0], wr[0]);
                else            macc += row_dot(xr[phase-1], wr[phase-1]);
                if (phase == 5) begin
                    exp_data  = finish_window(macc, bias);
                    exp_valid = 1;
                    phase     = x_valid ? 1 : 0;
                end else begin
                    phase++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("cyc_valid", int'(conv_valid), exp_valid);
            chk("cyc_data", int'($signed(conv_data)), exp_data);
        end
    end

    function automatic logic [44:0] fill(input int v);
        logic [44:0] r;
        logic [8:0]  e = 9'(v);
        for (int j = 0; j < 5; j++) r[9*j +: 9] = e;
        return r;
    endfunction

    task automatic set_all(input int xe, input int we);
        for (int k = 0; k < 5; k++) begin
            xr[k] = fill(xe);
            wr[k] = fill(we);
        end
    endtask

    task automatic set_unit();
        for (int k = 0; k < 5; k++) begin
            xr[k] = '0;
            wr[k] = '0;
        end
        xr[0] = 45'd16;
        wr[0] = 45'd16;
    endtask

    task automatic wait_valid(input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!conv_valid && n < 20);
        if (!conv_valid) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic no_pulse(input string name, input int cycles);
        int cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (conv_valid) cnt++;
        end
        chk(name, cnt, 0);
    endtask

    // one-cycle x_valid pulse; caller has set rows and bias
    task automatic launch_single(input string name, input int lit);
        int n;
        @(negedge clk);
        x_valid = 1'b1;
        @(negedge clk);
        x_valid = 1'b0;
        wait_valid(name, n);
        chk({name, "_lat"}, n, 5);
        chk(name, int'($signed(conv_data)), lit);
        chk({name, "_model"}, exp_data, lit);
        no_pulse({name, "_quiet"}, 8);
    endtask

    initial begin
        int n;
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rstn = 1'b0; x_valid = 1'b0; bias = '0;
        set_all(0, 0);
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(conv_valid), 0);
        chk("rst_data", int'(conv_data), 0);
        #2 rstn = 1'b1;
        no_pulse("idle_quiet", 6);
        chk("idle_data", int'(conv_data), 0);

        // default vector: elements [64,-95,3,0,0], raw 65650 -> 4103 -> 255
        for (int k = 0; k < 5; k++) begin
            xr[k] = 45'd1000000;
            wr[k] = 45'd1000000;
        end
        x_valid = 1'b1;
        wait_valid("pos1", n);
        chk("pos1_lat", n, 6);
        chk("pos1_data", int'($signed(conv_data)), 255);
        chk("pos1_model", exp_data, 255);
        wait_valid("pos2", n);
        chk("pos2_spacing", n, 5);
        x_valid = 1'b0;
        wait_valid("pos3", n);
        chk("pos3_spacing", n, 5);
        no_pulse("pos_quiet", 12);

        set_unit();
        bias = 9'd0;
        launch_single("unit", 16);
        bias = 9'd5;
        launch_single("unit_b5", 21);
        bias = 9'h1EC;
        launch_single("unit_bm20", -4);

        set_all(-256, 255);
        bias = 9'd0;
        launch_single("sat_neg", -256);

        // x_valid dropped while in m_3
        set_unit();
        @(negedge clk);
        x_valid = 1'b1;
        repeat (3) @(negedge clk);
        x_valid = 1'b0;
        wait_valid("drop_m3", n);
        chk("drop_m3_lat", n, 3);
        chk("drop_m3_data", int'($signed(conv_data)), 16);
        no_pulse("drop_m3_quiet", 12);

        // reset during m_3 of a saturating window
        set_all(-256, 255);
        @(negedge clk);
        x_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b0;
        x_valid = 1'b0;
        #1;
        chk("abort_valid", int'(conv_valid), 0);
        chk("abort_data", int'(conv_data), 0);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        no_pulse("abort_quiet", 8);
        chk("abort_hold", int'(conv_data), 0);
        set_unit();
        bias = 9'd5;
        launch_single("after_abort", 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
